// File: rtl/fifo_ram_ctrl_if.sv
// ---------------------------------------------------------------------------
// fifo_ram_ctrl_if
// Bundles the producer/consumer handshake and the RAM port signals of the
// FIFO controller.
//
// Modports:
//   slave  : the controller. It receives wr_en/wr_data/rd_en/ram_read_data
//            and drives the flags, read data and RAM write/read ports.
//   master : the environment (producer, consumer and RAM) facing the
//            controller.
//
// Handshake: a push (wr_en) is taken on the rising edge only while full is
// low. A pop (rd_en) is taken on the rising edge only while empty is low.
// A pop that is taken returns its word on rd_data, with rd_valid high for
// exactly one cycle after that edge. A request made against the wrong flag
// is dropped. No retry is implied.
//
// Optional macro FIFO_CTRL_ERR_FLAG_EN adds the sticky overflow/underflow
// outputs.
// ---------------------------------------------------------------------------
interface fifo_ram_ctrl_if #(
   parameter int WIDTH     = 8,
   parameter int DEPTH_LOG = 8
);
   logic                 wr_en;
   logic [WIDTH-1:0]     wr_data;
   logic                 rd_en;
   logic [WIDTH-1:0]     rd_data;
   logic                 rd_valid;
   logic                 full;
   logic                 empty;
   logic [DEPTH_LOG:0]   count;
   logic                 ram_write_req;
   logic [DEPTH_LOG-1:0] ram_write_addr;
   logic [WIDTH-1:0]     ram_write_data;
   logic [DEPTH_LOG-1:0] ram_read_addr;
   logic [WIDTH-1:0]     ram_read_data;
   logic [1:0]           state_dbg;
`ifdef FIFO_CTRL_ERR_FLAG_EN
   logic                 overflow;
   logic                 underflow;

   modport slave (
      input  wr_en, wr_data, rd_en, ram_read_data,
      output rd_data, rd_valid, full, empty, count,
      output ram_write_req, ram_write_addr, ram_write_data, ram_read_addr,
      output state_dbg, overflow, underflow
   );
   modport master (
      output wr_en, wr_data, rd_en, ram_read_data,
      input  rd_data, rd_valid, full, empty, count,
      input  ram_write_req, ram_write_addr, ram_write_data, ram_read_addr,
      input  state_dbg, overflow, underflow
   );
`else
   modport slave (
      input  wr_en, wr_data, rd_en, ram_read_data,
      output rd_data, rd_valid, full, empty, count,
      output ram_write_req, ram_write_addr, ram_write_data, ram_read_addr,
      output state_dbg
   );
   modport master (
      output wr_en, wr_data, rd_en, ram_read_data,
      input  rd_data, rd_valid, full, empty, count,
      input  ram_write_req, ram_write_addr, ram_write_data, ram_read_addr,
      input  state_dbg
   );
`endif
endinterface

// File: rtl/fifo_ram_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_ram_ctrl
// Synchronous FIFO controller that sequences an external dual-port RAM
// (one synchronous write port, one asynchronous read port).
//
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : fifo_ram_ctrl_if.slave
//          wr_en/wr_data      push request and data
//          rd_en              pop request
//          rd_data/rd_valid   registered pop data and one-cycle strobe
//          full/empty/count   occupancy flags and count (0..2**DEPTH_LOG)
//          ram_write_*        RAM write port (combinational)
//          ram_read_addr      RAM read address (combinational)
//          ram_read_data      RAM asynchronous read data
//          state_dbg          occupancy state: 0 EMPTY, 1 PARTIAL, 2 FULL
//          overflow/underflow sticky error flags (FIFO_CTRL_ERR_FLAG_EN only)
//
// Optional macro: FIFO_CTRL_ERR_FLAG_EN enables the sticky overflow and
// underflow flags. Without it, rejected requests are silently dropped.
// ---------------------------------------------------------------------------
module fifo_ram_ctrl #(
   parameter int WIDTH     = 8,
   parameter int DEPTH_LOG = 8
) (
   input  logic            clk,
   input  logic            rst,
   fifo_ram_ctrl_if.slave  bus
);
   localparam int PW = DEPTH_LOG + 1;
   localparam logic [PW-1:0] PTR_ONE    = {{DEPTH_LOG{1'b0}}, 1'b1};
   localparam logic [PW-1:0] DEPTH_FULL = {1'b1, {DEPTH_LOG{1'b0}}};

   typedef enum logic [1:0] {
      ST_EMPTY   = 2'd0,
      ST_PARTIAL = 2'd1,
      ST_FULL    = 2'd2
   } state_t;

   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    count_q;
   logic [PW-1:0]    count_d;
   logic [WIDTH-1:0] rd_data_q;
   logic             rd_valid_q;
   logic             full_w;
   logic             empty_w;
   logic             wr_acc;
   logic             rd_acc;
   state_t           state_q;
   state_t           state_d;

   // The MSB of each pointer is a wrap bit. Equal pointers mean empty.
   // Equal low bits with different wrap bits mean full.
   assign empty_w = (wr_ptr == rd_ptr);
   assign full_w  = (wr_ptr[DEPTH_LOG-1:0] == rd_ptr[DEPTH_LOG-1:0]) &&
                    (wr_ptr[DEPTH_LOG] != rd_ptr[DEPTH_LOG]);

   assign wr_acc = bus.wr_en & ~full_w;
   assign rd_acc = bus.rd_en & ~empty_w;

   // RAM ports follow the pointers and inputs combinationally. The RAM
   // captures the word on the same edge that advances wr_ptr.
   assign bus.ram_write_req  = wr_acc;
   assign bus.ram_write_addr = wr_ptr[DEPTH_LOG-1:0];
   assign bus.ram_write_data = bus.wr_data;
   assign bus.ram_read_addr  = rd_ptr[DEPTH_LOG-1:0];

   assign bus.full      = full_w;
   assign bus.empty     = empty_w;
   assign bus.count     = count_q;
   assign bus.rd_data   = rd_data_q;
   assign bus.rd_valid  = rd_valid_q;
   assign bus.state_dbg = state_q;

   always_comb begin
      count_d = count_q;
      case ({wr_acc, rd_acc})
         2'b10:   count_d = count_q + PTR_ONE;
         2'b01:   count_d = count_q - PTR_ONE;
         default: count_d = count_q;
      endcase
   end

   // Occupancy state follows the count that the next edge will load.
   always_comb begin
      state_d = state_q;
      if (count_d == '0)
         state_d = ST_EMPTY;
      else if (count_d == DEPTH_FULL)
         state_d = ST_FULL;
      else
         state_d = ST_PARTIAL;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state_q <= ST_EMPTY;
      else
         state_q <= state_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count_q    <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         count_q <= count_d;
         if (wr_acc)
            wr_ptr <= wr_ptr + PTR_ONE;
         if (rd_acc) begin
            rd_ptr     <= rd_ptr + PTR_ONE;
            rd_data_q  <= bus.ram_read_data;
            rd_valid_q <= 1'b1;
         end else begin
            rd_valid_q <= 1'b0;
         end
      end
   end

`ifdef FIFO_CTRL_ERR_FLAG_EN
   logic overflow_q;
   logic underflow_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         if (bus.wr_en & full_w)
            overflow_q <= 1'b1;
         if (bus.rd_en & empty_w)
            underflow_q <= 1'b1;
      end
   end

   assign bus.overflow  = overflow_q;
   assign bus.underflow = underflow_q;
`endif

endmodule
